// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side and issue-side handshake bundle for decode_stage.
//   slave  - decoder view: takes in_* and out_ready, drives in_ready and out_*.
//   master - environment view: drives in_* and out_ready, observes the rest.
//   XLEN   - datapath width, 32 or 64; sizes pc and immediate.
interface decode_stage_if #(parameter int XLEN = 64);
  logic            in_valid, in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] out_pc, out_imm;
  logic [4:0]      out_rd, out_rs1, out_rs2;
  logic [3:0]      out_alu_op;
  logic            out_word, out_reg_write, out_is_load, out_is_store, out_is_branch, out_is_jump;
  logic [1:0]      out_mem_size;
  logic            out_mem_unsigned, out_illegal;
  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_imm, out_rd, out_rs1, out_rs2, out_alu_op, out_word,
           out_reg_write, out_is_load, out_is_store, out_is_branch, out_is_jump, out_mem_size,
           out_mem_unsigned, out_illegal
  );
  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_imm, out_rd, out_rs1, out_rs2, out_alu_op, out_word,
           out_reg_write, out_is_load, out_is_store, out_is_branch, out_is_jump, out_mem_size,
           out_mem_unsigned, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered RV32IM/RV64IM decoder with a DEPTH-entry output queue.
//   clk   - clock
//   reset - synchronous, active-low; clears queue and storage
//   bus   - decode_stage_if.slave: in_* instruction handshake, out_* decoded bundle at queue head
// Optional: define DECODE_TRACE_EN to print one disassembly line per accepted instruction.
module decode_stage #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input logic          clk,
  input logic          reset,
  decode_stage_if.slave bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam bit R64 = XLEN == 64;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd, rs1, rs2;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu_op;
    logic            word, reg_write, is_load, is_store, is_branch, is_jump;
    logic [1:0]      mem_size;
    logic            mem_unsigned, illegal;
  } bundle_t;
  function automatic logic [3:0] alu_f3(input logic [2:0] f, input logic alt);
    case (f)
      3'd0:    return alt ? 4'd2 : 4'd1;
      3'd1:    return 4'd8;
      3'd2:    return 4'd11;
      3'd3:    return 4'd12;
      3'd4:    return 4'd5;
      3'd5:    return alt ? 4'd10 : 4'd9;
      3'd6:    return 4'd7;
      default: return 4'd6;
    endcase
  endfunction
  logic [31:0]     i;
  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic [4:0]      rd, rs1, rs2;
  logic            shift, ok, live, push, pop;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;
  bundle_t         d, h;
  bundle_t         mem [DEPTH];
  logic [AW-1:0]   wp, rp;
  logic [AW:0]     cnt;
  assign i     = bus.in_instr;
  assign opc   = i[6:0];
  assign rd    = i[11:7];
  assign f3    = i[14:12];
  assign rs1   = i[19:15];
  assign rs2   = i[24:20];
  assign f7    = i[31:25];
  assign shift = f3[1:0] == 2'b01;
  assign imm_i = XLEN'($signed(i[31:20]));
  assign imm_s = XLEN'($signed({i[31:25], i[11:7]}));
  assign imm_b = XLEN'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({i[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
  assign shamt = XLEN'(i[25:20]);
  always_comb begin
    d    = '0;
    d.pc = bus.in_pc;
    ok   = 1'b1;
    case (opc)
      7'b0110111, 7'b0010111: begin
        d.rd = rd; d.imm = imm_u; d.alu_op = 4'd1; d.reg_write = 1'b1;
      end
      7'b1101111: begin
        d.rd = rd; d.imm = imm_j; d.is_jump = 1'b1; d.reg_write = 1'b1;
      end
      7'b1100111: begin
        d.rd = rd; d.rs1 = rs1; d.imm = imm_i; d.is_jump = 1'b1; d.reg_write = 1'b1;
        ok = f3 == 3'd0;
      end
      7'b1100011: begin
        d.rs1 = rs1; d.rs2 = rs2; d.imm = imm_b; d.is_branch = 1'b1;
        ok = f3[2:1] != 2'b01;
      end
      7'b0000011: begin
        d.rd = rd; d.rs1 = rs1; d.imm = imm_i; d.alu_op = 4'd1; d.is_load = 1'b1; d.reg_write = 1'b1;
        d.mem_size = f3[1:0]; d.mem_unsigned = f3[2];
        ok = f3 != 3'd7 && (R64 || (f3 != 3'd3 && f3 != 3'd6));
      end
      7'b0100011: begin
        d.rs1 = rs1; d.rs2 = rs2; d.imm = imm_s; d.alu_op = 4'd1; d.is_store = 1'b1; d.mem_size = f3[1:0];
        ok = !f3[2] && (R64 || f3 != 3'd3);
      end
      7'b0010011: begin
        d.rd = rd; d.rs1 = rs1; d.imm = shift ? shamt : imm_i; d.reg_write = 1'b1;
        d.alu_op = alu_f3(f3, f3 == 3'd5 && i[30]);
        // shift-immediates: only bit 30 may be set above the shamt; bit 25 needs a 64-bit shamt
        ok = !shift || ((i[31:26] & 6'b101111) == 6'd0 && !(f3 == 3'd1 && i[30]) && (R64 || !i[25]));
      end
      7'b0011011: begin
        d.rd = rd; d.rs1 = rs1; d.imm = shift ? shamt : imm_i; d.word = 1'b1; d.reg_write = 1'b1;
        d.alu_op = alu_f3(f3, f3 == 3'd5 && i[30]);
        ok = R64 && (f3 == 3'd0 || (f3 == 3'd1 && f7 == 7'd0) || (f3 == 3'd5 && (f7 & 7'b1011111) == 7'd0));
      end
      7'b0110011, 7'b0111011: begin
        d.rd = rd; d.rs1 = rs1; d.rs2 = rs2; d.word = opc[3]; d.reg_write = 1'b1;
        d.alu_op = f7 == 7'd1 ? (f3[2] ? (f3[1] ? 4'd13 : 4'd4) : 4'd3) : alu_f3(f3, f7[5]);
        ok = opc[3]
          ? R64 && ((f7 == 7'd0 && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5)) ||
                    (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)) ||
                    (f7 == 7'd1 && (f3 == 3'd0 || f3[2])))
          : f7 == 7'd0 || f7 == 7'd1 || (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5));
      end
      default: ok = 1'b0;
    endcase
    d.illegal   = !ok;
    d.reg_write = d.reg_write && ok && d.rd != 5'd0;
    if (!ok) {d.alu_op, d.word, d.is_load, d.is_store, d.is_branch, d.is_jump, d.mem_size, d.mem_unsigned} = 12'd0;
  end
  // live holds in_ready low through reset and for the edge that releases it
  assign bus.in_ready  = live && cnt != (AW+1)'(DEPTH);
  assign bus.out_valid = cnt != '0;
  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;
  always_ff @(posedge clk)
    if (!reset) begin
      live <= 1'b0;
      wp   <= '0;
      rp   <= '0;
      cnt  <= '0;
      mem  <= '{default: '0};
    end else begin
      live <= 1'b1;
      if (push) begin
        mem[wp] <= d;
        wp      <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  assign h                    = mem[rp];
  assign bus.out_pc           = h.pc;
  assign bus.out_rd           = h.rd;
  assign bus.out_rs1          = h.rs1;
  assign bus.out_rs2          = h.rs2;
  assign bus.out_imm          = h.imm;
  assign bus.out_alu_op       = h.alu_op;
  assign bus.out_word         = h.word;
  assign bus.out_reg_write    = h.reg_write;
  assign bus.out_is_load      = h.is_load;
  assign bus.out_is_store     = h.is_store;
  assign bus.out_is_branch    = h.is_branch;
  assign bus.out_is_jump      = h.is_jump;
  assign bus.out_mem_size     = h.mem_size;
  assign bus.out_mem_unsigned = h.mem_unsigned;
  assign bus.out_illegal      = h.illegal;
`ifdef DECODE_TRACE_EN
  function automatic string mnem(input logic [31:0] w, input logic [3:0] op, input logic wd);
    string s;
    case (w[6:0])
      7'b0110111: s = "lui";
      7'b0010111: s = "auipc";
      7'b1101111: s = "jal";
      7'b1100111: s = "jalr";
      7'b1100011: s = w[14:12] == 3'd0 ? "beq" : w[14:12] == 3'd1 ? "bne" : w[14:12] == 3'd4 ? "blt" :
                      w[14:12] == 3'd5 ? "bge" : w[14:12] == 3'd6 ? "bltu" : "bgeu";
      7'b0000011, 7'b0100011:
        s = $sformatf("%s%s%s", w[5] ? "s" : "l",
                      w[13:12] == 2'd0 ? "b" : w[13:12] == 2'd1 ? "h" : w[13:12] == 2'd2 ? "w" : "d",
                      w[14] ? "u" : "");
      default: begin
        case (op)
          4'd1:    s = "add";
          4'd2:    s = "sub";
          4'd3:    s = "mul";
          4'd4:    s = "div";
          4'd5:    s = "xor";
          4'd6:    s = "and";
          4'd7:    s = "or";
          4'd8:    s = "sll";
          4'd9:    s = "srl";
          4'd10:   s = "sra";
          4'd11:   s = "slt";
          4'd12:   s = "sltu";
          default: s = "rem";
        endcase
        s = $sformatf("%s%s%s", s, w[5] ? "" : "i", wd ? "w" : "");
      end
    endcase
    return s;
  endfunction
  always_ff @(posedge clk)
    if (reset && push) begin
      if (d.illegal)
        $display("%h: illegal %b %b %b %b %b %b", bus.in_pc, f7, rs2, rs1, f3, rd, opc);
      else if (i == 32'h00000013) $display("%h: nop", bus.in_pc);
      else if (i == 32'h00008067) $display("%h: ret", bus.in_pc);
      else if (opc == 7'b0010011 && f3 == 3'd0 && i[31:20] == 12'd0)
        $display("%h: mv x%0d, x%0d", bus.in_pc, rd, rs1);
      else if (opc == 7'b0010011 && f3 == 3'd0 && rs1 == 5'd0)
        $display("%h: li x%0d, %0d", bus.in_pc, rd, $signed(d.imm));
      else if (opc == 7'b1101111 && rd == 5'd0)
        $display("%h: j %0d", bus.in_pc, $signed(d.imm));
      else if (opc == 7'b1100011 && rs2 == 5'd0 && f3[2:1] == 2'b00)
        $display("%h: %s x%0d, %0d", bus.in_pc, f3[0] ? "bnez" : "beqz", rs1, $signed(d.imm));
      else
        $display("%h: %s rd=x%0d rs1=x%0d rs2=x%0d imm=%0d", bus.in_pc, mnem(i, d.alu_op, d.word),
                 d.rd, d.rs1, d.rs2, $signed(d.imm));
    end
`endif
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed checks of decode_stage at XLEN=64 and XLEN=32 side by side.
module tb_decode_stage;
  logic clk = 1'b0, reset = 1'b0;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  decode_stage_if #(.XLEN(64)) b64 ();
  decode_stage_if #(.XLEN(32)) b32 ();
  assign b32.in_valid  = b64.in_valid;
  assign b32.in_instr  = b64.in_instr;
  assign b32.in_pc     = b64.in_pc[31:0];
  assign b32.out_ready = b64.out_ready;
  decode_stage #(.XLEN(64), .DEPTH(2)) u64 (.clk(clk), .reset(reset), .bus(b64));
  decode_stage #(.XLEN(32), .DEPTH(2)) u32 (.clk(clk), .reset(reset), .bus(b32));
  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    logic        ci;
    int          rd, rs1, rs2, alu, size;
    logic [7:0]  fl;
    logic        ill32;
  } vec_t;
  // fl = {reg_write, load, store, branch, jump, word, mem_unsigned, illegal}; -1 = not checked
  vec_t vecs [13] = '{
    '{32'hFFF08293, 64'hFFFFFFFFFFFFFFFF, 1'b1,  5,  1, -1,  1, -1, 8'b1000_0000, 1'b0},
    '{32'h123451B7, 64'h0000000012345000, 1'b1,  3, -1, -1, -1, -1, 8'b1000_0000, 1'b0},
    '{32'h0020B423, 64'd8,                1'b1, -1,  1,  2, -1,  3, 8'b0010_0000, 1'b1},
    '{32'h42115093, 64'h21,               1'b1,  1,  2, -1, 10, -1, 8'b1000_0000, 1'b1},
    '{32'h003100BB, 64'd0,                1'b0,  1,  2,  3,  1, -1, 8'b1000_0100, 1'b1},
    '{32'h027302B3, 64'd0,                1'b0,  5,  6,  7,  3, -1, 8'b1000_0000, 1'b0},
    '{32'hFE009CE3, 64'hFFFFFFFFFFFFFFF8, 1'b1, -1,  1,  0,  0, -1, 8'b0001_0000, 1'b0},
    '{32'h0032C203, 64'd3,                1'b1,  4,  5, -1, -1,  0, 8'b1100_0010, 1'b0},
    '{32'h00000000, 64'd0,                1'b0, -1, -1, -1,  0, -1, 8'b0000_0001, 1'b1},
    '{32'h00000013, 64'd0,                1'b1,  0,  0, -1,  1, -1, 8'b0000_0000, 1'b0},
    '{32'h010000EF, 64'd16,               1'b1,  1, -1, -1, -1, -1, 8'b1000_1000, 1'b0},
    '{32'h402081B3, 64'd0,                1'b0,  3,  1,  2,  2, -1, 8'b1000_0000, 1'b0},
    '{32'hFF013303, 64'hFFFFFFFFFFFFFFF0, 1'b1,  6,  2, -1, -1,  3, 8'b1100_0000, 1'b1}
  };
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] pc);
    b64.in_valid = v;
    b64.in_instr = ins;
    b64.in_pc    = pc;
  endtask
  initial begin
    drive(1'b0, 32'h0, 64'h0);
    b64.out_ready = 1'b0;
    repeat (3) tick;
    check("rst_out_valid", b64.out_valid, 0);
    check("rst_in_ready", b64.in_ready, 0);
    check("rst_out_imm", b64.out_imm, 0);
    check("rst_out_pc", b64.out_pc, 0);
    reset = 1'b1;
    check("rel_in_ready_same_cycle", b64.in_ready, 0);
    tick;
    check("rel_in_ready", b64.in_ready, 1);
    check("rel_out_valid", b64.out_valid, 0);
    b64.out_ready = 1'b1;
    foreach (vecs[k]) begin
      drive(1'b1, vecs[k].instr, 64'h1000 + 64'(4 * k));
      tick;
      check($sformatf("v%0d_out_valid", k), b64.out_valid, 1);
      check($sformatf("v%0d_in_ready", k), b64.in_ready, 1);
      check($sformatf("v%0d_pc", k), b64.out_pc, 64'h1000 + 64'(4 * k));
      check($sformatf("v%0d_flags", k), {b64.out_reg_write, b64.out_is_load, b64.out_is_store,
            b64.out_is_branch, b64.out_is_jump, b64.out_word, b64.out_mem_unsigned, b64.out_illegal}, vecs[k].fl);
      if (vecs[k].ci) check($sformatf("v%0d_imm", k), b64.out_imm, vecs[k].imm);
      if (vecs[k].rd >= 0) check($sformatf("v%0d_rd", k), b64.out_rd, 64'(vecs[k].rd));
      if (vecs[k].rs1 >= 0) check($sformatf("v%0d_rs1", k), b64.out_rs1, 64'(vecs[k].rs1));
      if (vecs[k].rs2 >= 0) check($sformatf("v%0d_rs2", k), b64.out_rs2, 64'(vecs[k].rs2));
      if (vecs[k].alu >= 0) check($sformatf("v%0d_alu", k), b64.out_alu_op, 64'(vecs[k].alu));
      if (vecs[k].size >= 0) check($sformatf("v%0d_size", k), b64.out_mem_size, 64'(vecs[k].size));
      check($sformatf("v%0d_ill32", k), b32.out_illegal, 64'(vecs[k].ill32));
      if (vecs[k].ill32)
        check($sformatf("v%0d_ill32_clear", k), {b32.out_reg_write, b32.out_alu_op, b32.out_is_load,
              b32.out_is_store, b32.out_is_branch, b32.out_is_jump, b32.out_word}, 0);
      else if (vecs[k].ci)
        check($sformatf("v%0d_imm32", k), b32.out_imm, 64'(vecs[k].imm[31:0]));
    end
    drive(1'b0, 32'h0, 64'h0);
    tick;
    check("stream_drain", b64.out_valid, 0);
    b64.out_ready = 1'b0;
    drive(1'b1, 32'hFFF08293, 64'h200);
    tick;
    check("bp_ready_after_1", b64.in_ready, 1);
    drive(1'b1, 32'h123451B7, 64'h204);
    tick;
    check("bp_ready_after_2", b64.in_ready, 0);
    check("bp_head_a", b64.out_pc, 64'h200);
    drive(1'b1, 32'h0020B423, 64'h208);
    tick;
    check("bp_held_ready", b64.in_ready, 0);
    check("bp_stable_pc", b64.out_pc, 64'h200);
    check("bp_stable_rd", b64.out_rd, 5);
    b64.out_ready = 1'b1;
    tick;
    check("bp_head_b", b64.out_pc, 64'h204);
    check("bp_ready_after_pop", b64.in_ready, 1);
    tick;
    drive(1'b0, 32'h0, 64'h0);
    check("bp_head_c", b64.out_pc, 64'h208);
    check("bp_head_c_store", b64.out_is_store, 1);
    tick;
    check("bp_empty", b64.out_valid, 0);
    b64.out_ready = 1'b0;
    drive(1'b1, 32'hFFF08293, 64'h300);
    tick;
    drive(1'b1, 32'h123451B7, 64'h304);
    tick;
    check("mr_queued", b64.out_valid, 1);
    drive(1'b0, 32'h0, 64'h0);
    reset = 1'b0;
    tick;
    check("mr_out_valid", b64.out_valid, 0);
    check("mr_in_ready", b64.in_ready, 0);
    check("mr_out_pc", b64.out_pc, 0);
    reset = 1'b1;
    tick;
    check("mr_ready_back", b64.in_ready, 1);
    b64.out_ready = 1'b1;
    drive(1'b1, 32'h027302B3, 64'h400);
    tick;
    drive(1'b0, 32'h0, 64'h0);
    check("mr_first_pc", b64.out_pc, 64'h400);
    check("mr_first_alu", b64.out_alu_op, 3);
    tick;
    check("mr_nothing_more", b64.out_valid, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
